modexp_seq: RTL and testbench

MODEXP_SEQ -- requirements
Module: modexp_seq

---
 rtl/modexp_seq.sv | 176 +++++++++++++++++
 tb/tb_modexp_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/modexp_seq.sv
// Square-and-multiply modular exponentiation sequencer driving two external multipliers.
// One cycle per issue plus the slowest issued multiplier per exponent bit; no backpressure on start.
module modexp_seq #(
   parameter int OP_W = 528,
   parameter int EXP_W = 32,
   parameter logic [OP_W-1:0] R_ONE = {{(OP_W-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             abort,
   input  logic [OP_W-1:0]  base_in,
   input  logic [EXP_W-1:0] exp_in,
   input  logic [OP_W-1:0]  mult_in,
   output logic             busy,
   output logic             done,
   output logic [OP_W-1:0]  result,
   output logic             sq_start,
   output logic [OP_W-1:0]  sq_a,
   output logic [OP_W-1:0]  sq_b,
   input  logic             sq_done,
   input  logic [OP_W-1:0]  sq_p,
   output logic             acc_start,
   output logic [OP_W-1:0]  acc_a,
   output logic [OP_W-1:0]  acc_b,
   input  logic             acc_done,
   input  logic [OP_W-1:0]  acc_p
);

   localparam int CNT_W = $clog2(EXP_W + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FINISH, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [OP_W-1:0]    s_q, s_d, a_q, a_d, m_q, m_d;
   logic [EXP_W-1:0]   e_q, e_d;
   logic               mode_q, mode_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sq_iss_q, sq_iss_d, acc_iss_q, acc_iss_d;
   logic               sq_got_q, sq_got_d, acc_got_q, acc_got_d;
   logic [OP_W-1:0]    sq_pr_q, sq_pr_d, acc_pr_q, acc_pr_d;
   logic [OP_W-1:0]    result_q, result_d;

   logic               sq_ok, acc_ok, all_ok;
   logic [OP_W-1:0]    sq_val, acc_val;

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FINISH);
   assign result    = result_q;
   assign sq_start  = (state_q == ISSUE) && !mode_q && ((e_q >> 1) != '0);
   assign acc_start = (state_q == ISSUE) && (mode_q || e_q[0]);
   assign sq_a      = s_q;
   assign sq_b      = s_q;
   assign acc_a     = mode_q ? s_q : a_q;
   assign acc_b     = mode_q ? m_q : s_q;

   // A channel is settled if it was never issued, already reported, or reports now.
   assign sq_ok   = !sq_iss_q || sq_got_q || sq_done;
   assign acc_ok  = !acc_iss_q || acc_got_q || acc_done;
   assign all_ok  = sq_ok && acc_ok;
   assign sq_val  = sq_got_q ? sq_pr_q : sq_p;
   assign acc_val = acc_got_q ? acc_pr_q : acc_p;

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      a_d       = a_q;
      m_d       = m_q;
      e_d       = e_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      sq_iss_d  = sq_iss_q;
      acc_iss_d = acc_iss_q;
      sq_got_d  = sq_got_q;
      acc_got_d = acc_got_q;
      sq_pr_d   = sq_pr_q;
      acc_pr_d  = acc_pr_q;
      result_d  = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               s_d       = base_in;
               e_d       = exp_in;
               m_d       = mult_in;
               mode_d    = mode;
               a_d       = R_ONE;
               cnt_d     = '0;
               sq_iss_d  = 1'b0;
               acc_iss_d = 1'b0;
               sq_got_d  = 1'b0;
               acc_got_d = 1'b0;
               if (!mode && exp_in == '0) begin
                  state_d  = FINISH;
                  result_d = R_ONE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            sq_iss_d  = sq_start;
            acc_iss_d = acc_start;
            sq_got_d  = 1'b0;
            acc_got_d = 1'b0;
            state_d   = abort ? DRAIN : WAIT;
         end
         WAIT: begin
            if (sq_iss_q && sq_done) begin
               sq_got_d = 1'b1;
               sq_pr_d  = sq_p;
            end
            if (acc_iss_q && acc_done) begin
               acc_got_d = 1'b1;
               acc_pr_d  = acc_p;
            end
            if (abort) begin
               state_d = DRAIN;
            end else if (all_ok) begin
               if (acc_iss_q) a_d = acc_val;
               if (sq_iss_q)  s_d = sq_val;
               e_d   = e_q >> 1;
               cnt_d = cnt_q + CNT_W'(1);
               if (mode_q || e_d == '0 || cnt_d == CNT_W'(EXP_W)) begin
                  state_d  = FINISH;
                  result_d = a_d;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         FINISH: state_d = IDLE;
         DRAIN: begin
            if (sq_iss_q && sq_done)   sq_got_d  = 1'b1;
            if (acc_iss_q && acc_done) acc_got_d = 1'b1;
            if (all_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         s_q       <= '0;
         a_q       <= '0;
         m_q       <= '0;
         e_q       <= '0;
         mode_q    <= 1'b0;
         cnt_q     <= '0;
         sq_iss_q  <= 1'b0;
         acc_iss_q <= 1'b0;
         sq_got_q  <= 1'b0;
         acc_got_q <= 1'b0;
         sq_pr_q   <= '0;
         acc_pr_q  <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         a_q       <= a_d;
         m_q       <= m_d;
         e_q       <= e_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         sq_iss_q  <= sq_iss_d;
         acc_iss_q <= acc_iss_d;
         sq_got_q  <= sq_got_d;
         acc_got_q <= acc_got_d;
         sq_pr_q   <= sq_pr_d;
         acc_pr_q  <= acc_pr_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_modexp_seq.sv
// Bench for modexp_seq with behavioural mod-1000 multipliers of programmable latency.
module tb_modexp_seq;
   localparam int OP_W = 32;
   localparam int EXP_W = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0, mode = 1'b0, abort = 1'b0;
   logic [OP_W-1:0]  base_in = '0, mult_in = '0;
   logic [EXP_W-1:0] exp_in = '0;
   logic             busy, done;
   logic [OP_W-1:0]  result;
   logic             sq_start, acc_start;
   logic [OP_W-1:0]  sq_a, sq_b, acc_a, acc_b;
   logic             sq_done = 1'b0, acc_done = 1'b0;
   logic [OP_W-1:0]  sq_p = '0, acc_p = '0;

   int ncmp = 0, nerr = 0;
   int sq_lat = 3, acc_lat = 3, sq_cnt = 0, acc_cnt = 0, n_sq = 0, n_acc = 0;

   modexp_seq #(.OP_W(OP_W), .EXP_W(EXP_W), .R_ONE(32'd1)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
      .base_in(base_in), .exp_in(exp_in), .mult_in(mult_in),
      .busy(busy), .done(done), .result(result),
      .sq_start(sq_start), .sq_a(sq_a), .sq_b(sq_b), .sq_done(sq_done), .sq_p(sq_p),
      .acc_start(acc_start), .acc_a(acc_a), .acc_b(acc_b), .acc_done(acc_done), .acc_p(acc_p)
   );

   always #5 clk = ~clk;

   // Multipliers: done is sampled L edges after the edge that samples start; product uses operands at done time.
   always @(negedge clk) begin
      sq_done  = 1'b0;
      acc_done = 1'b0;
      if (sq_cnt > 0) begin
         sq_cnt--;
         if (sq_cnt == 0) begin
            sq_done = 1'b1;
            sq_p = OP_W'((longint'(sq_a) * longint'(sq_b)) % 1000);
         end
      end
      if (acc_cnt > 0) begin
         acc_cnt--;
         if (acc_cnt == 0) begin
            acc_done = 1'b1;
            acc_p = OP_W'((longint'(acc_a) * longint'(acc_b)) % 1000);
         end
      end
      if (sq_start)  begin sq_cnt = sq_lat;   n_sq++;  end
      if (acc_start) begin acc_cnt = acc_lat; n_acc++; end
   end

   task automatic check(input string nm, input longint act, input longint exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int ref_result(input logic md, input int b, input int ex, input int mul);
      int r;
      if (md) return (b * mul) % 1000;
      r = 1;
      repeat (ex) r = (r * b) % 1000;
      return r;
   endfunction

   // One pass per exponent bit up to the top set bit; each pass costs 1 + slowest multiplier used.
   function automatic int ref_cycles(input logic md, input int ex, input int sl, input int al);
      int top, c, m;
      if (md) return 2 + al;
      if (ex == 0) return 1;
      top = 0;
      for (int i = 0; i < EXP_W; i++) if ((ex >> i) & 1) top = i;
      c = 1;
      for (int i = 0; i <= top; i++) begin
         m = (i < top) ? sl : 0;
         if (((ex >> i) & 1) && al > m) m = al;
         c += 1 + m;
      end
      return c;
   endfunction

   task automatic run_op(input logic md, input int b, input int ex, input int mul,
                         input int sl, input int al, input int poke,
                         output int res, output int cyc, output int nsq, output int nacc);
      @(negedge clk);
      sq_lat = sl; acc_lat = al; n_sq = 0; n_acc = 0;
      mode = md; base_in = OP_W'(b); exp_in = EXP_W'(ex); mult_in = OP_W'(mul); start = 1'b1;
      cyc = 0;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == poke) begin
            start = 1'b1; mode = 1'b1; base_in = 7; mult_in = 9; exp_in = 1;
         end
         if (done) begin cyc = c; break; end
      end
      start = 1'b0;
      res = int'(result); nsq = n_sq; nacc = n_acc;
   endtask

   task automatic run_abort(input int sl, input int al, input int ab_cyc);
      int low_c, seen_done, prev;
      prev = int'(result);
      @(negedge clk);
      sq_lat = sl; acc_lat = al;
      mode = 1'b0; base_in = 3; exp_in = 13; mult_in = 0; start = 1'b1;
      low_c = 0; seen_done = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         start = 1'b0;
         abort = (c == ab_cyc);
         if (done) seen_done = 1;
         if (!busy) begin low_c = c; break; end
      end
      abort = 1'b0;
      check("abort_busy_low_cycle", low_c, 2 + ((sl > al) ? sl : al));
      check("abort_no_done", seen_done, 0);
      check("abort_result_kept", int'(result), prev);
   endtask

   typedef struct {
      logic md; int b; int ex; int mul; int sl; int al;
      int res; int cyc; int nsq; int nacc;
   } vec_t;

   initial begin
      vec_t tbl[7];
      int res, cyc, nsq, nacc, md, b, ex, mul, sl, al, bad;
      tbl[0] = '{1'b0, 3, 13, 0, 3, 3, 323, 17, 3, 3};
      tbl[1] = '{1'b0, 5, 0, 0, 3, 3, 1, 1, 0, 0};
      tbl[2] = '{1'b1, 7, 0, 9, 3, 3, 63, 5, 0, 1};
      tbl[3] = '{1'b0, 5, 3, 0, 5, 2, 125, 10, 1, 2};
      tbl[4] = '{1'b0, 999, 2, 0, 1, 1, 1, 5, 1, 1};
      tbl[5] = '{1'b0, 7, 1, 0, 2, 2, 7, 4, 0, 1};
      tbl[6] = '{1'b0, 1, 2048, 0, 1, 1, 1, 25, 11, 1};

      #1 rst = 1'b1;
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);
      check("reset_sq_start", sq_start, 0);
      check("reset_acc_start", acc_start, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         run_op(tbl[i].md, tbl[i].b, tbl[i].ex, tbl[i].mul, tbl[i].sl, tbl[i].al, 0, res, cyc, nsq, nacc);
         check($sformatf("vec%0d_result", i), res, tbl[i].res);
         check($sformatf("vec%0d_cycle", i), cyc, tbl[i].cyc);
         check($sformatf("vec%0d_sq_pulses", i), nsq, tbl[i].nsq);
         check($sformatf("vec%0d_acc_pulses", i), nacc, tbl[i].nacc);
         @(negedge clk);
         check($sformatf("vec%0d_done_single", i), done, 0);
         check($sformatf("vec%0d_result_hold", i), int'(result), tbl[i].res);
      end

      for (int i = 0; i < 25; i++) begin
         md = $urandom_range(0, 1);
         b = $urandom_range(0, 999);
         mul = $urandom_range(0, 999);
         ex = $urandom_range(0, 4095);
         if ($urandom_range(0, 3) == 0) ex = ex | 32'h800;
         sl = $urandom_range(1, 4);
         al = $urandom_range(1, 4);
         run_op(md[0], b, ex, mul, sl, al, 0, res, cyc, nsq, nacc);
         check($sformatf("rand%0d_result", i), res, ref_result(md[0], b, ex, mul));
         check($sformatf("rand%0d_cycle", i), cyc, ref_cycles(md[0], ex, sl, al));
      end

      run_abort(3, 3, 3);
      run_abort(6, 2, 2);
      run_abort(2, 4, 1);
      run_op(1'b0, 3, 13, 0, 3, 3, 0, res, cyc, nsq, nacc);
      check("after_abort_result", res, 323);
      check("after_abort_cycle", cyc, 17);

      // Reset in WAIT; the square channel returns long after reset is released.
      @(negedge clk);
      sq_lat = 6; acc_lat = 3;
      mode = 1'b0; base_in = 3; exp_in = 13; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_result", result, 0);
      check("midrst_sq_start", sq_start, 0);
      check("midrst_acc_start", acc_start, 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || result !== '0) bad++;
      end
      check("post_reset_quiet", bad, 0);

      run_op(1'b0, 3, 13, 0, 3, 3, 3, res, cyc, nsq, nacc);
      check("start_ignored_busy_result", res, 323);
      check("start_ignored_busy_cycle", cyc, 17);
      run_op(1'b1, 7, 0, 9, 3, 3, 0, res, cyc, nsq, nacc);
      check("start_accepted_idle_result", res, 63);
      check("start_accepted_idle_cycle", cyc, 5);

      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end
endmodule
